div_run_ctrl: RTL and testbench

- Run sequencer for the program-2 (8-bit divide) flow on the CPU.
- Accepts a dividend/divisor request from a host and writes both operands into data memory.
- Holds the CPU in reset, pulses start, waits for the CPU ack, reads the quotient and remainder back from data memory, and returns them with a status code and cycle count.
- Owns the data-memory port whenever the CPU is not running. An external mux driven by dm_own selects between this block and the CPU core port.

---
 rtl/div_run_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_div_run_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_run_ctrl.sv
// div_run_ctrl: run sequencer for the 8-bit divide program on the CPU.
// It loads the operands into data memory and starts the CPU. When the CPU
// signals done it reads the quotient and remainder back and returns them to
// the host with a status code and the CPU run-cycle count. A zero divisor is
// answered directly and the CPU is never started. A run that never
// acknowledges is aborted after TIMEOUT cycles.
module div_run_ctrl #(
  parameter logic [7:0] ADDR_DIVIDEND = 8'd0,
  parameter logic [7:0] ADDR_DIVISOR  = 8'd1,
  parameter logic [7:0] ADDR_QUOT     = 8'd4,
  parameter logic [7:0] ADDR_REM      = 8'd5,
  parameter int         TIMEOUT       = 4096,
  parameter int         CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  // host request
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_dividend,
  input  logic [7:0]       req_divisor,
  // host response
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [7:0]       resp_quotient,
  output logic [7:0]       resp_remainder,
  output logic [1:0]       resp_status,
  output logic [CNT_W-1:0] resp_cycles,
  // CPU control
  output logic             cpu_reset,
  output logic             cpu_start,
  input  logic             cpu_ack,
  // data-memory port (muxed externally by dm_own)
  output logic             dm_own,
  output logic             dm_we,
  output logic [7:0]       dm_addr,
  output logic [7:0]       dm_wdata,
  input  logic [7:0]       dm_rdata
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD0,
    S_LOAD1,
    S_START,
    S_RUN,
    S_RD_Q,
    S_RD_R,
    S_CAPT,
    S_RESP
  } state_t;

  localparam logic [1:0]       ST_OK      = 2'b00;
  localparam logic [1:0]       ST_DIV0    = 2'b01;
  localparam logic [1:0]       ST_TIMEOUT = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_dividend;
  logic [7:0]       r_divisor;
  logic [CNT_W-1:0] r_cnt;
  logic             r_resp_valid;
  logic [7:0]       r_quot;
  logic [7:0]       r_rem;
  logic [1:0]       r_status;
  logic [CNT_W-1:0] r_cycles;
  logic             w_accept;
  logic             w_cnt_last;

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // State register; reset returns to IDLE from any state, abandoning a run.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode plus the control outputs that follow the state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    req_ready    = 1'b0;
    cpu_reset    = 1'b1;
    cpu_start    = 1'b0;
    dm_own       = 1'b1;
    dm_we        = 1'b0;
    dm_addr      = 8'd0;
    dm_wdata     = 8'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = (req_divisor == 8'd0) ? S_RESP : S_LOAD0;
        end
      end
      S_LOAD0: begin
        dm_we        = 1'b1;
        dm_addr      = ADDR_DIVIDEND;
        dm_wdata     = r_dividend;
        w_state_next = S_LOAD1;
      end
      S_LOAD1: begin
        dm_we        = 1'b1;
        dm_addr      = ADDR_DIVISOR;
        dm_wdata     = r_divisor;
        w_state_next = S_START;
      end
      S_START: begin
        cpu_start    = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        dm_own    = 1'b0;
        // An ack on the final counted cycle still wins over the timeout.
        if (cpu_ack)         w_state_next = S_RD_Q;
        else if (w_cnt_last) w_state_next = S_RESP;
      end
      S_RD_Q: begin
        cpu_reset    = 1'b0;
        dm_addr      = ADDR_QUOT;
        w_state_next = S_RD_R;
      end
      S_RD_R: begin
        cpu_reset    = 1'b0;
        dm_addr      = ADDR_REM;
        w_state_next = S_CAPT;
      end
      S_CAPT: begin
        cpu_reset    = 1'b0;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // While reset is held the outputs show their idle values immediately.
    if (reset) begin
      req_ready = 1'b0;
      cpu_reset = 1'b1;
      cpu_start = 1'b0;
      dm_own    = 1'b1;
      dm_we     = 1'b0;
      dm_addr   = 8'd0;
      dm_wdata  = 8'd0;
    end
  end

  // Operand latch and the saturating CPU run-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dividend <= 8'd0;
      r_divisor  <= 8'd0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_dividend <= req_dividend;
        r_divisor  <= req_divisor;
      end
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if (r_state == S_RUN && !cpu_ack && !w_cnt_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Registered response fields, filled in along the path taken to RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_quot       <= 8'd0;
      r_rem        <= 8'd0;
      r_status     <= ST_OK;
      r_cycles     <= '0;
    end else begin
      r_resp_valid <= (w_state_next == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_divisor == 8'd0) begin
            r_quot   <= 8'hFF;
            r_rem    <= req_dividend;
            r_status <= ST_DIV0;
            r_cycles <= '0;
          end
        end
        S_RUN: begin
          if (cpu_ack) begin
            r_cycles <= r_cnt;
          end else if (w_cnt_last) begin
            r_quot   <= 8'd0;
            r_rem    <= 8'd0;
            r_status <= ST_TIMEOUT;
            r_cycles <= CNT_LAST;
          end
        end
        S_RD_R: r_quot <= dm_rdata;
        S_CAPT: begin
          r_rem    <= dm_rdata;
          r_status <= ST_OK;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid     = r_resp_valid & ~reset;
  assign resp_quotient  = reset ? 8'd0 : r_quot;
  assign resp_remainder = reset ? 8'd0 : r_rem;
  assign resp_status    = reset ? ST_OK : r_status;
  assign resp_cycles    = reset ? '0 : r_cycles;

endmodule

// File: tb/tb_div_run_ctrl.sv
// Testbench for div_run_ctrl. It provides a data-memory model with a
// registered read port and a CPU stub. The stub divides DM[0] by DM[1] into
// DM[4]/DM[5] on its first run cycle and acks after a chosen delay. Expected
// responses come from a transaction-level reference model.
module tb_div_run_ctrl;

  localparam int TO    = 32;
  localparam int CNT_W = 16;
  localparam int NEVER = 1 << 20;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic [1:0] st;
    int         cyc;
    int         lat;
    int         writes;
    int         starts;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [7:0]       req_dividend, req_divisor;
  logic             resp_valid, resp_ready;
  logic [7:0]       resp_quotient, resp_remainder;
  logic [1:0]       resp_status;
  logic [CNT_W-1:0] resp_cycles;
  logic             cpu_reset, cpu_start, cpu_ack;
  logic             dm_own, dm_we;
  logic [7:0]       dm_addr, dm_wdata, dm_rdata;

  int checks = 0;
  int errors = 0;

  div_run_ctrl #(
    .ADDR_DIVIDEND(8'd0), .ADDR_DIVISOR(8'd1), .ADDR_QUOT(8'd4), .ADDR_REM(8'd5),
    .TIMEOUT(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_status(resp_status), .resp_cycles(resp_cycles),
    .cpu_reset(cpu_reset), .cpu_start(cpu_start), .cpu_ack(cpu_ack),
    .dm_own(dm_own), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- environment: CPU stub and data memory ----------------
  int         ack_delay  = NEVER;
  logic       force_ack  = 1'b0;
  logic       stub_ack   = 1'b0;
  logic       stub_wr    = 1'b0;
  int         run_cnt    = 0;
  logic [7:0] dm [256];

  assign cpu_ack = stub_ack | force_ack;

  always @(negedge clk) begin
    if (cpu_reset) begin
      run_cnt  = 0;
      stub_ack = 1'b0;
      stub_wr  = 1'b0;
    end else begin
      stub_wr  = (run_cnt == 0);
      stub_ack = (run_cnt == ack_delay);
      run_cnt++;
    end
  end

  always @(posedge clk) begin
    if (dm_own && dm_we) begin
      dm[dm_addr] = dm_wdata;
    end else if (!dm_own && stub_wr && dm[1] != 8'd0) begin
      dm[4] = dm[0] / dm[1];
      dm[5] = dm[0] % dm[1];
    end
    dm_rdata <= dm[dm_addr];
  end

  // Event counters sampled mid-cycle.
  int wr_count = 0, start_count = 0, start_bad = 0;
  always @(negedge clk) begin
    if (dm_own && dm_we) wr_count++;
    if (cpu_start) begin
      start_count++;
      if (!cpu_reset) start_bad++;
    end
  end

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [7:0] dd, input logic [7:0] dv, input int delay);
    exp_t e;
    if (dv == 8'd0) begin
      e = '{q: 8'hFF, r: dd, st: 2'b01, cyc: 0, lat: 1, writes: 0, starts: 0};
    end else if (delay <= TO - 1) begin
      e = '{q: dd / dv, r: dd % dv, st: 2'b00, cyc: delay, lat: 8 + delay, writes: 2, starts: 1};
    end else begin
      e = '{q: 8'd0, r: 8'd0, st: 2'b10, cyc: TO - 1, lat: 4 + TO, writes: 2, starts: 1};
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- transaction helpers ----------------
  exp_t       ex;
  logic [7:0] cur_dd, cur_dv;
  int         wr_base, st_base, bad_base;

  task automatic prep(input logic [7:0] dd, input logic [7:0] dv, input int delay);
    ack_delay = delay;
    cur_dd    = dd;
    cur_dv    = dv;
    ex        = model(dd, dv, delay);
    wr_base   = wr_count;
    st_base   = start_count;
    bad_base  = start_bad;
  endtask

  // Leaves the bench at the negedge of the first cycle after acceptance.
  task automatic issue(input logic [7:0] dd, input logic [7:0] dv, input int delay);
    int n = 0;
    prep(dd, dv, delay);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_issue", 32'(req_ready), 1);
    req_valid    = 1'b1;
    req_dividend = dd;
    req_divisor  = dv;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_check(input string tag);
    int lat = 1;
    while (!resp_valid && lat < TO + 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(ex.lat));
    check({tag, "_quot"},    32'(resp_quotient), 32'(ex.q));
    check({tag, "_rem"},     32'(resp_remainder), 32'(ex.r));
    check({tag, "_status"},  32'(resp_status), 32'(ex.st));
    check({tag, "_cycles"},  32'(resp_cycles), 32'(ex.cyc));
    check({tag, "_dm_writes"}, 32'(wr_count - wr_base), 32'(ex.writes));
    check({tag, "_starts"},  32'(start_count - st_base), 32'(ex.starts));
    check({tag, "_start_in_reset"}, 32'(start_bad - bad_base), 0);
    if (ex.writes != 0) begin
      check({tag, "_dm0"}, 32'(dm[0]), 32'(cur_dd));
      check({tag, "_dm1"}, 32'(dm[1]), 32'(cur_dv));
    end
  endtask

  task automatic release_resp(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_valid_dropped"}, 32'(resp_valid), 0);
    check({tag, "_idle_ready"},    32'(req_ready), 1);
    check({tag, "_cpu_held"},      32'(cpu_reset), 1);
  endtask

  task automatic txn(input string tag, input logic [7:0] dd, input logic [7:0] dv, input int delay);
    issue(dd, dv, delay);
    wait_check(tag);
    release_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  exp_t       exp_a;
  logic [7:0] rdd, rdv;
  int         rdel;

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_dividend = 8'd0;
    req_divisor  = 8'd0;
    resp_ready   = 1'b0;
    repeat (3) @(negedge clk);

    // Values while reset is held.
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_quot",       32'(resp_quotient), 0);
    check("rst_rem",        32'(resp_remainder), 0);
    check("rst_status",     32'(resp_status), 0);
    check("rst_cycles",     32'(resp_cycles), 0);
    check("rst_cpu_reset",  32'(cpu_reset), 1);
    check("rst_cpu_start",  32'(cpu_start), 0);
    check("rst_dm_own",     32'(dm_own), 1);
    check("rst_dm_we",      32'(dm_we), 0);
    check("rst_dm_addr",    32'(dm_addr), 0);
    check("rst_dm_wdata",   32'(dm_wdata), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 1);

    // Normal run: 43/12 with ack on run cycle 20.
    txn("normal", 8'd43, 8'd12, 20);
    // Divide by zero: answered directly.
    txn("div0", 8'd9, 8'd0, 0);
    // Timeout: the stub never acks.
    txn("timeout", 8'd200, 8'd7, NEVER);
    // Ack coincides with the last allowed cycle: ack wins.
    txn("tie", 8'd255, 8'd1, TO - 1);
    // Ack in the first run cycle.
    txn("first_cycle", 8'd100, 8'd9, 0);

    // Backpressure with a second request pending.
    issue(8'd77, 8'd5, 3);
    wait_check("bp_a");
    exp_a = ex;
    prep(8'd50, 8'd6, 2);
    req_valid    = 1'b1;
    req_dividend = 8'd50;
    req_divisor  = 8'd6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(resp_valid), 1);
      check("bp_hold_quot",  32'(resp_quotient), 32'(exp_a.q));
      check("bp_hold_rem",   32'(resp_remainder), 32'(exp_a.r));
      check("bp_hold_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_idle_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_check("bp_b");
    release_resp("bp_b");

    // Reset in the middle of a run, then a late ack.
    issue(8'd60, 8'd4, NEVER);
    repeat (5) @(negedge clk);
    check("midrun_cpu_running", 32'(cpu_reset), 0);
    check("midrun_dm_released", 32'(dm_own), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun_rst_cpu_reset",  32'(cpu_reset), 1);
    check("midrun_rst_dm_own",     32'(dm_own), 1);
    check("midrun_rst_resp_valid", 32'(resp_valid), 0);
    force_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("late_ack_no_resp", 32'(resp_valid), 0);
      check("late_ack_idle",    32'(req_ready), 1);
    end
    force_ack = 1'b0;

    // Randomized transactions against the reference model.
    for (int i = 0; i < 14; i++) begin
      rdd = 8'($urandom);
      rdv = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rdel = 0;
        1:       rdel = TO - 1;
        2:       rdel = TO;
        default: rdel = int'($urandom_range(0, TO + 3));
      endcase
      txn("random", rdd, rdv, rdel);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
